// File: rtl/lerp_upsampler.sv
// lerp_upsampler
//   Upsampling stage between the output FIFO and the DAC driver. Every clock
//   it emits one sample obtained by linear interpolation between consecutive
//   FIFO samples, giving an upsample factor N = 2**SAMPLE_RATE. When the FIFO
//   runs dry it holds the last sample and counts the missed fetches.
//
// Ports
//   clk          in   system clock
//   rst_in       in   asynchronous active-low reset
//   ena          in   start permission (only looked at in IDLE)
//   fifo_empty   in   output-FIFO empty flag
//   fifo_dout    in   signed FIFO data, valid the cycle after rd_en
//   rd_en        out  FIFO read strobe, single-cycle pulses, never on empty
//   dac_data     out  registered signed interpolated sample
//   out_valid    out  registered, high while in RUN or HOLD
//   underrun     out  sticky flag, set on the first failed fetch
//   underrun_cnt out  saturating count of failed fetches
module lerp_upsampler #(
  parameter int DATA_WIDTH  = 14,
  parameter int SAMPLE_RATE = 4
) (
  input  logic                         clk,
  input  logic                         rst_in,
  input  logic                         ena,
  input  logic                         fifo_empty,
  input  logic signed [DATA_WIDTH-1:0] fifo_dout,
  output logic                         rd_en,
  output logic signed [DATA_WIDTH-1:0] dac_data,
  output logic                         out_valid,
  output logic                         underrun,
  output logic [15:0]                  underrun_cnt
);

  localparam int AW  = DATA_WIDTH + SAMPLE_RATE + 1;
  localparam int DW1 = DATA_WIDTH + 1;
  // Phase at which the next sample is requested, and the last phase of a period.
  localparam logic [SAMPLE_RATE-1:0] PH_FETCH = SAMPLE_RATE'((32'd1 << SAMPLE_RATE) - 32'd2);
  localparam logic [SAMPLE_RATE-1:0] PH_LAST  = SAMPLE_RATE'((32'd1 << SAMPLE_RATE) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Sample scaled into accumulator units (x * N), sign-extended.
  function automatic logic signed [AW-1:0] scale_up(input logic signed [DATA_WIDTH-1:0] x);
    return AW'(x) <<< SAMPLE_RATE;
  endfunction

  // Accumulator back to sample units; arithmetic shift gives floor rounding.
  function automatic logic signed [DATA_WIDTH-1:0] scale_down(input logic signed [AW-1:0] a);
    return DATA_WIDTH'(a >>> SAMPLE_RATE);
  endfunction

  // One extra bit so a full-scale step cannot overflow.
  function automatic logic signed [DW1-1:0] step(input logic signed [DATA_WIDTH-1:0] nxt,
                                                 input logic signed [DATA_WIDTH-1:0] cur);
    return DW1'(nxt) - DW1'(cur);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t                         state_q, state_d;
  logic [SAMPLE_RATE-1:0]         ph_q, ph_d;
  logic signed [DATA_WIDTH-1:0]   x1_q, x1_d;
  logic signed [DW1-1:0]          delta_q, delta_d;
  logic signed [AW-1:0]           acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]   dac_data_q, dac_data_d;
  logic                           out_valid_q, out_valid_d;
  logic                           underrun_q, underrun_d;
  logic [15:0]                    underrun_cnt_q, underrun_cnt_d;
  logic                           fetched_q;
  logic                           have_s0_q, have_s0_d;
  logic                           fetch_req;

  // The strobe is combinational so it can never fire on an empty FIFO,
  // and it is held off while reset is asserted.
  assign rd_en        = rst_in & fetch_req & ~fifo_empty;
  assign dac_data     = dac_data_q;
  assign out_valid    = out_valid_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

  // Next-state and datapath computation for the interpolation FSM.
  always_comb begin
    state_d        = state_q;
    ph_d           = ph_q;
    x1_d           = x1_q;
    delta_d        = delta_q;
    acc_d          = acc_q;
    dac_data_d     = dac_data_q;
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;
    have_s0_d      = have_s0_q;
    fetch_req      = 1'b0;

    case (state_q)
      IDLE: begin
        dac_data_d = '0;
        have_s0_d  = 1'b0;
        fetch_req  = ena;
        if (ena && !fifo_empty) begin
          state_d = PRIME;
        end else begin
          state_d = IDLE;
        end
      end

      PRIME: begin
        dac_data_d = '0;
        if (!have_s0_q) begin
          // s0 is on fifo_dout: this cycle follows the IDLE read strobe.
          x1_d      = fifo_dout;
          have_s0_d = 1'b1;
        end else if (fetched_q) begin
          acc_d   = scale_up(x1_q);
          delta_d = step(fifo_dout, x1_q);
          x1_d    = fifo_dout;
          ph_d    = '0;
          state_d = RUN;
        end else begin
          // Keep asking for s1 until the FIFO has something.
          fetch_req = 1'b1;
        end
      end

      RUN: begin
        dac_data_d = scale_down(acc_q);
        ph_d       = ph_q + SAMPLE_RATE'(1'b1);
        fetch_req  = (ph_q == PH_FETCH);
        if (ph_q == PH_LAST) begin
          acc_d = scale_up(x1_q);
          if (fetched_q) begin
            delta_d = step(fifo_dout, x1_q);
            x1_d    = fifo_dout;
            state_d = RUN;
          end else begin
            delta_d        = '0;
            underrun_d     = 1'b1;
            underrun_cnt_d = sat_inc(underrun_cnt_q);
            state_d        = HOLD;
          end
        end else begin
          acc_d = acc_q + AW'(delta_q);
        end
      end

      HOLD: begin
        // acc sits at x1*N with zero slope, so the output is flat at x1.
        dac_data_d = scale_down(acc_q);
        ph_d       = ph_q + SAMPLE_RATE'(1'b1);
        fetch_req  = (ph_q == PH_FETCH);
        if (ph_q == PH_LAST) begin
          if (fetched_q) begin
            acc_d   = scale_up(x1_q);
            delta_d = step(fifo_dout, x1_q);
            x1_d    = fifo_dout;
            state_d = RUN;
          end else begin
            underrun_d     = 1'b1;
            underrun_cnt_d = sat_inc(underrun_cnt_q);
            state_d        = HOLD;
          end
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d    = IDLE;
        dac_data_d = '0;
        have_s0_d  = 1'b0;
      end
    endcase

    out_valid_d = (state_d == RUN) || (state_d == HOLD);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= IDLE;
      ph_q           <= '0;
      x1_q           <= '0;
      delta_q        <= '0;
      acc_q          <= '0;
      dac_data_q     <= '0;
      out_valid_q    <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 16'd0;
      fetched_q      <= 1'b0;
      have_s0_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ph_q           <= ph_d;
      x1_q           <= x1_d;
      delta_q        <= delta_d;
      acc_q          <= acc_d;
      dac_data_q     <= dac_data_d;
      out_valid_q    <= out_valid_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
      fetched_q      <= rd_en;
      have_s0_q      <= have_s0_d;
    end
  end

endmodule

// File: tb/tb_lerp_upsampler.sv
module tb_lerp_upsampler;

  localparam int DW = 14;
  localparam int SR = 2;
  localparam int N  = 4;

  logic                 clk = 1'b0;
  logic                 rst_in = 1'b0;
  logic                 ena = 1'b0;
  logic                 fifo_empty = 1'b1;
  logic signed [DW-1:0] fifo_dout = '0;
  logic                 rd_en;
  logic signed [DW-1:0] dac_data;
  logic                 out_valid;
  logic                 underrun;
  logic [15:0]          underrun_cnt;

  int tests = 0;
  int fails = 0;
  int q[$];        // FIFO contents
  int expq[$];     // expected dac_data stream
  bit block = 1'b0; // forces the FIFO to report empty

  lerp_upsampler #(.DATA_WIDTH(DW), .SAMPLE_RATE(SR)) dut (
    .clk(clk), .rst_in(rst_in), .ena(ena), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .rd_en(rd_en), .dac_data(dac_data),
    .out_valid(out_valid), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: standard read mode, data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en && q.size() > 0) fifo_dout <= DW'(q.pop_front());
    fifo_empty <= (q.size() == 0) || block;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // floor(v / N) for signed v
  function automatic int floor_div(int v);
    int r;
    r = v % N;
    if (r < 0) r = r + N;
    return (v - r) / N;
  endfunction

  // N output samples that linearly go from a toward b
  function automatic void add_ramp(int a, int b);
    for (int k = 0; k < N; k++) expq.push_back(floor_div(a * N + k * (b - a)));
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(16383)) - 8192;
  endfunction

  task automatic do_reset();
    rst_in = 1'b0;
    ena    = 1'b0;
    block  = 1'b0;
    q.delete();
    expq.delete();
    repeat (3) @(negedge clk);
    rst_in = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_valid: out_valid got %b, required 1 within 200 cycles", out_valid);
    end
  endtask

  // Compare the next n samples after out_valid rises against expq.
  task automatic check_stream(string name, int n);
    bit ok;
    logic signed [DW-1:0] e;
    wait_valid(ok);
    if (ok) begin
      for (int j = 0; j < n; j++) begin
        @(negedge clk);
        e = DW'(expq[j]);
        tests++;
        if (dac_data !== e) begin
          fails++;
          $display("FAIL %s[%0d]: dac_data got %0d, required %0d", name, j, dac_data, e);
        end
        tests++;
        if (rd_en && fifo_empty) begin
          fails++;
          $display("FAIL %s_rd_empty[%0d]: rd_en got 1 with fifo_empty=1, required 0", name, j);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if ({dac_data, out_valid, rd_en, underrun, underrun_cnt} !== {DW'(0), 1'b0, 1'b0, 1'b0, 16'd0}) begin
      fails++;
      $display("FAIL reset: dac=%0d ov=%b rd=%b ur=%b cnt=%0d, required all zero",
               dac_data, out_valid, rd_en, underrun, underrun_cnt);
    end
  endtask

  task automatic test_ramp();
    do_reset();
    q = '{0, 64, 128, 64};
    ena = 1'b1;
    add_ramp(0, 64);
    add_ramp(64, 128);
    add_ramp(128, 64);
    check_stream("ramp", 12);
  endtask

  task automatic test_full_scale();
    do_reset();
    q = '{-8192, 8191};
    ena = 1'b1;
    add_ramp(-8192, 8191);
    expq.push_back(8191);
    expq.push_back(8191);
    check_stream("full_scale", 6);
    tests++;
    if (underrun !== 1'b1 || underrun_cnt !== 16'd1) begin
      fails++;
      $display("FAIL full_scale_underrun: ur=%b cnt=%0d, required 1 and 1", underrun, underrun_cnt);
    end
  endtask

  task automatic test_random_stream();
    int s[10];
    do_reset();
    for (int i = 0; i < 10; i++) begin
      s[i] = rand_sample();
      q.push_back(s[i]);
    end
    ena = 1'b1;
    for (int i = 0; i < 9; i++) add_ramp(s[i], s[i+1]);
    check_stream("random", 36);
  endtask

  task automatic test_underrun_reset();
    bit ok;
    int bad;
    logic signed [DW-1:0] e;
    do_reset();
    q = '{100, 200, 300};
    ena = 1'b1;
    add_ramp(100, 200);
    add_ramp(200, 300);
    for (int i = 0; i < 8; i++) expq.push_back(300);
    add_ramp(300, 400);
    expq.push_back(400);
    wait_valid(ok);
    if (ok) begin
      for (int j = 0; j <= 20; j++) begin
        @(negedge clk);
        e = DW'(expq[j]);
        tests++;
        if (dac_data !== e) begin
          fails++;
          $display("FAIL underrun_seq[%0d]: dac_data got %0d, required %0d", j, dac_data, e);
        end
        if (j == 11) begin
          q.push_back(400);
          q.push_back(500);
          q.push_back(600);
        end
        if (j == 12 || j == 20) begin
          tests++;
          if (underrun !== 1'b1 || underrun_cnt !== 16'd2 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL underrun_cnt[%0d]: ur=%b cnt=%0d ov=%b, required 1, 2, 1",
                     j, underrun, underrun_cnt, out_valid);
          end
        end
      end
      // Mid-RUN asynchronous reset with a non-empty FIFO and ena high.
      rst_in = 1'b0;
      #1;
      tests++;
      if ({dac_data, out_valid, rd_en, underrun, underrun_cnt} !== {DW'(0), 1'b0, 1'b0, 1'b0, 16'd0}) begin
        fails++;
        $display("FAIL async_reset: dac=%0d ov=%b rd=%b ur=%b cnt=%0d, required all zero",
                 dac_data, out_valid, rd_en, underrun, underrun_cnt);
      end
      @(negedge clk);
      ena = 1'b0;
      rst_in = 1'b1;
      bad = 0;
      for (int i = 0; i < 3 * N; i++) begin
        @(negedge clk);
        if (rd_en !== 1'b0 || out_valid !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL idle_after_reset: %0d cycles with rd_en/out_valid high, required 0", bad);
      end
    end
  endtask

  task automatic test_rd_protocol();
    int cyc;
    int last_rd;
    int n_rd;
    do_reset();
    for (int i = 0; i < 4; i++) q.push_back(rand_sample());
    ena = 1'b1;
    last_rd = -1000;
    n_rd = 0;
    for (cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      tests++;
      if (rd_en && fifo_empty) begin
        fails++;
        $display("FAIL rd_on_empty: cycle %0d rd_en got 1 with fifo_empty=1, required 0", cyc);
      end
      if (rd_en) begin
        if (out_valid) begin
          tests++;
          if (cyc - last_rd < N) begin
            fails++;
            $display("FAIL rd_spacing: cycle %0d gap got %0d, required >= %0d", cyc, cyc - last_rd, N);
          end
        end
        last_rd = cyc;
        n_rd++;
      end
      block = ($urandom_range(2) == 0);
      if (q.size() < 3 && $urandom_range(1) == 1) q.push_back(rand_sample());
    end
    block = 1'b0;
    tests++;
    if (n_rd < 20) begin
      fails++;
      $display("FAIL rd_activity: rd_en pulses got %0d, required >= 20", n_rd);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_full_scale();
    test_random_stream();
    test_underrun_reset();
    test_rd_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
